// File: rtl/note_pkg.sv
// note_pkg: shared tone table, voice state encoding and counter width
// for the note tone generator.
package note_pkg;
    localparam int CNT_W = 17;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        PLAY   = 2'd1,
        GAP    = 2'd2
    } voice_state_t;

    // Half-periods in 50 MHz clock cycles, C4 up to C5.
    localparam logic [CNT_W-1:0] HP_TABLE [8] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    function automatic logic [2:0] top_bit(input logic [7:0] n);
        top_bit = 3'd0;
        for (int i = 0; i < 8; i++)
            if (n[i]) top_bit = 3'(i);
    endfunction
endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice with a silent articulation gap
// between consecutive different notes.
module tone_voice
    import note_pkg::*;
#(
    parameter int SIM_SHIFT  = 0,
    parameter int GAP_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] note,
    output logic       tone,
    output logic       active
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    voice_state_t     state;
    logic             sq;
    logic [2:0]       cur;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    gcnt;
    logic [2:0]       idx;
    logic [CNT_W-1:0] reload_new, reload_cur;

    assign idx        = top_bit(note);
    assign reload_new = (HP_TABLE[idx] >> SIM_SHIFT) - 1'b1;
    assign reload_cur = (HP_TABLE[cur] >> SIM_SHIFT) - 1'b1;
    assign active     = state == PLAY;
    assign tone       = sq & active;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SILENT;
            sq    <= 1'b0;
            cur   <= 3'd0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            case (state)
                SILENT: if (note != 8'd0) begin
                    state <= PLAY;
                    sq    <= 1'b1;
                    cnt   <= reload_new;
                    cur   <= idx;
                end
                PLAY: if (note == 8'd0) begin
                    state <= SILENT;
                    sq    <= 1'b0;
                end else if (idx != cur) begin
                    state <= GAP;
                    sq    <= 1'b0;
                    gcnt  <= GW'(GAP_CYCLES - 1);
                    cur   <= idx;
                end else if (cnt == '0) begin
                    sq  <= ~sq;
                    cnt <= reload_cur;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                GAP: if (note == 8'd0) begin
                    state <= SILENT;
                end else begin
                    cur <= idx;
                    // The tone resumes on whatever note is current when the gap ends.
                    if (gcnt == '0) begin
                        state <= PLAY;
                        sq    <= 1'b1;
                        cnt   <= reload_new;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                default: state <= SILENT;
            endcase
        end
    end
endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: registers the two track note words, gates them by playback
// and track select, and mixes two square-wave voices onto the JA header.
module note_tone_gen
    import note_pkg::*;
#(
    parameter int SIM_SHIFT  = 0,
    parameter int GAP_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       read,
    input  logic       cs1,
    input  logic       cs2,
    input  logic [7:0] tones1,
    input  logic [7:0] tones2,
    output logic [3:0] ja,
    output logic       active1,
    output logic       active2
);
    logic [7:0] tones1_q, tones2_q;
    logic       cs1_q, cs2_q, read_q;
    logic [7:0] note1, note2;
    logic       tone1, tone2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tones1_q <= 8'd0;
            tones2_q <= 8'd0;
            cs1_q    <= 1'b0;
            cs2_q    <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            tones1_q <= tones1;
            tones2_q <= tones2;
            cs1_q    <= cs1;
            cs2_q    <= cs2;
            read_q   <= read;
        end
    end

    assign note1 = (read_q && cs1_q) ? tones1_q : 8'd0;
    assign note2 = (read_q && cs2_q) ? tones2_q : 8'd0;

    tone_voice #(.SIM_SHIFT(SIM_SHIFT), .GAP_CYCLES(GAP_CYCLES)) u_voice1 (
        .clock(clock), .reset(reset), .note(note1), .tone(tone1), .active(active1)
    );
    tone_voice #(.SIM_SHIFT(SIM_SHIFT), .GAP_CYCLES(GAP_CYCLES)) u_voice2 (
        .clock(clock), .reset(reset), .note(note2), .tone(tone2), .active(active2)
    );

    // XOR mixing only when both voices sound, so a lone voice passes unchanged.
    assign ja[1] = tone1;
    assign ja[2] = tone2;
    assign ja[3] = active1 | active2;
    assign ja[0] = (active1 && active2) ? (tone1 ^ tone2) : (tone1 | tone2);
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: random and directed stimulus against a cycle-count
// reference model; expected outputs flow through a queue to a monitor.
module tb_note_tone_gen;
    localparam int SH  = 10;
    localparam int GAP = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       read = 1'b0, cs1 = 1'b0, cs2 = 1'b0;
    logic [7:0] tones1 = 8'd0, tones2 = 8'd0;
    logic [3:0] ja;
    logic       active1, active2;

    always #5 clock = ~clock;

    note_tone_gen #(.SIM_SHIFT(SH), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .read(read), .cs1(cs1), .cs2(cs2),
        .tones1(tones1), .tones2(tones2), .ja(ja), .active1(active1), .active2(active2)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_q[$];

    int hp_tab[8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
    int mode[2];
    int cur[2];
    int t[2];
    int g[2];
    logic [7:0] reg_note[2];

    function automatic int hp(input int i);
        return hp_tab[i] >> SH;
    endfunction

    function automatic int floor_log2(input logic [7:0] n);
        int x = int'(n);
        int r = -1;
        while (x > 0) begin
            x = x >> 1;
            r++;
        end
        return r;
    endfunction

    // mode: 0 silent, 1 play (t cycles since tone start), 2 gap (g cycles elapsed)
    function automatic void voice_step(input int v, input logic [7:0] n);
        int i;
        if (n == 8'd0) begin
            mode[v] = 0;
            return;
        end
        i = floor_log2(n);
        case (mode[v])
            0: begin mode[v] = 1; cur[v] = i; t[v] = 0; end
            1: if (i != cur[v]) begin mode[v] = 2; cur[v] = i; g[v] = 0; end
               else t[v]++;
            default: begin
                cur[v] = i;
                if (g[v] == GAP - 1) begin mode[v] = 1; t[v] = 0; end
                else g[v]++;
            end
        endcase
    endfunction

    function automatic logic sq(input int v);
        return mode[v] == 1 && ((t[v] / hp(cur[v])) % 2 == 0);
    endfunction

    task automatic cycle(input logic r, input logic rd, input logic c1, input logic c2,
                         input logic [7:0] n1, input logic [7:0] n2);
        logic v1, v2, p1, p2, mix;
        @(negedge clock);
        reset = r; read = rd; cs1 = c1; cs2 = c2; tones1 = n1; tones2 = n2;
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                mode[k] = 0; cur[k] = 0; t[k] = 0; g[k] = 0; reg_note[k] = 8'd0;
            end
        end else begin
            voice_step(0, reg_note[0]);
            voice_step(1, reg_note[1]);
            reg_note[0] = (rd && c1) ? n1 : 8'd0;
            reg_note[1] = (rd && c2) ? n2 : 8'd0;
        end
        v1 = sq(0); v2 = sq(1);
        p1 = mode[0] == 1; p2 = mode[1] == 1;
        mix = (p1 && p2) ? (v1 ^ v2) : (v1 | v2);
        exp_q.push_back({p1 | p2, v2, v1, mix, p1, p2});
    endtask

    task automatic hold(input int n, input logic r, input logic rd, input logic c1,
                        input logic c2, input logic [7:0] n1, input logic [7:0] n2);
        for (int i = 0; i < n; i++) cycle(r, rd, c1, c2, n1, n2);
    endtask

    function automatic logic [7:0] rnd_note();
        int r = $urandom_range(0, 9);
        if (r < 2) return 8'd0;
        if (r < 7) return 8'(1 << $urandom_range(0, 7));
        return 8'($urandom);
    endfunction

    initial begin
        logic [5:0] e;
        wait (exp_q.size() > 0);
        forever begin
            @(posedge clock);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: no expected value queued", $time);
            end else begin
                e = exp_q.pop_front();
                if ({ja, active1, active2} !== e) begin
                    miscompares++;
                    $display("FAIL ja_active at %0t: got ja=%b a1=%b a2=%b, want ja=%b a1=%b a2=%b",
                             $time, ja, active1, active2, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; cur[k] = 0; t[k] = 0; g[k] = 0; reg_note[k] = 8'd0;
        end
        hold(6, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        hold(300, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        hold(100, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
        hold(150, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h00);
        hold(200, 1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
        hold(400, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h80);
        hold(20, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h80);
        hold(60, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h08);
        hold(3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h08);
        hold(50, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h08);
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0)
                hold($urandom_range(1, 4), 1'b0, 1'b1, 1'b1, 1'b1, rnd_note(), rnd_note());
            else
                hold($urandom_range(1, 150), 1'b1, $urandom_range(0, 5) != 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     rnd_note(), rnd_note());
        end
        @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
